// File: rtl/aes_spi_frontend.sv
// aes_spi_frontend: SPI slave that loads a 256-bit frame and returns the AES result.
// Optional: AES_SPI_LEN_CHECK_EN rejects frames whose length is not 256 bits.
module aes_spi_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sck,
  input  logic         sdi,
  output logic         sdo,
  input  logic         load,
  output logic         done,
  output logic [127:0] plaintext,
  output logic [127:0] key,
  output logic         start,
  input  logic         core_done,
  input  logic [127:0] cyphertext
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_q, sdi_q, load_q;
  logic sck_d1_q, load_d1_q;
  logic sck_s, sdi_s, load_s;
  logic sck_rise, sck_fall;
  logic load_rise, load_fall;

  logic [255:0] in_sr_q;
  logic [8:0]   in_cnt_q;
  logic [127:0] out_sr_q;
  logic [7:0]   out_cnt_q;

  logic start_q, start_d;
  logic done_q, done_d;
  logic in_clr, in_shift;
  logic out_cap, out_shift;

`ifdef AES_SPI_LEN_CHECK_EN
  logic len_err_q, len_err_d;
`endif

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_q[SYNC_STAGES-1];
  assign load_s = load_q[SYNC_STAGES-1];

  assign sck_rise  = sck_s & ~sck_d1_q;
  assign sck_fall  = ~sck_s & sck_d1_q;
  assign load_rise = load_s & ~load_d1_q;
  assign load_fall = ~load_s & load_d1_q;

  assign plaintext = in_sr_q[255:128];
  assign key       = in_sr_q[127:0];
  assign start     = start_q;
  assign done      = done_q;
  assign sdo       = (state_q == DONE) &&
                     (out_cnt_q != 8'd128) &&
                     out_sr_q[127];

  // Pin synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q     <= '0;
      sdi_q     <= '0;
      load_q    <= '0;
      sck_d1_q  <= 1'b0;
      load_d1_q <= 1'b0;
    end else begin
      sck_q     <= {sck_q[SYNC_STAGES-2:0], sck};
      sdi_q     <= {sdi_q[SYNC_STAGES-2:0], sdi};
      load_q    <= {load_q[SYNC_STAGES-2:0], load};
      sck_d1_q  <= sck_s;
      load_d1_q <= load_s;
    end
  end

  // State and handshake flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_SPI_LEN_CHECK_EN
      len_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
`ifdef AES_SPI_LEN_CHECK_EN
      len_err_q <= len_err_d;
`endif
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    done_d    = done_q;
    in_clr    = 1'b0;
    in_shift  = 1'b0;
    out_cap   = 1'b0;
    out_shift = 1'b0;
`ifdef AES_SPI_LEN_CHECK_EN
    len_err_d = len_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_s) begin
          state_d = LOAD;
          in_clr  = 1'b1;
`ifdef AES_SPI_LEN_CHECK_EN
          len_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        in_shift = sck_rise;
        if (load_fall) begin
`ifdef AES_SPI_LEN_CHECK_EN
          if (in_cnt_q == 9'd256) begin
            state_d = BUSY;
            start_d = 1'b1;
          end else begin
            state_d   = IDLE;
            len_err_d = 1'b1;
          end
`else
          state_d = BUSY;
          start_d = 1'b1;
`endif
        end
      end
      BUSY: begin
        if (core_done) begin
          state_d = DONE;
          done_d  = 1'b1;
          out_cap = 1'b1;
        end
      end
      DONE: begin
        if (load_rise) begin
          state_d = LOAD;
          done_d  = 1'b0;
          in_clr  = 1'b1;
`ifdef AES_SPI_LEN_CHECK_EN
          len_err_d = 1'b0;
`endif
        end else if (sck_fall &&
                     out_cnt_q != 8'd128) begin
          out_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Input frame shifter with saturating bit count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_sr_q  <= '0;
      in_cnt_q <= '0;
    end else if (in_clr) begin
      in_cnt_q <= '0;
    end else if (in_shift) begin
      in_sr_q <= {in_sr_q[254:0], sdi_s};
      if (in_cnt_q != 9'd256) begin
        in_cnt_q <= in_cnt_q + 9'd1;
      end
    end
  end

  // Result capture and MSB-first output shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sr_q  <= '0;
      out_cnt_q <= '0;
    end else if (out_cap) begin
      out_sr_q  <= cyphertext;
      out_cnt_q <= '0;
    end else if (out_shift) begin
      out_sr_q  <= {out_sr_q[126:0], 1'b0};
      out_cnt_q <= out_cnt_q + 8'd1;
    end
  end

endmodule
